hvac_sequencer: RTL and testbench
=================================

# hvac_sequencer

Sequences the air-conditioning actuators from the heating/cooling demand produced by the temperature monitor. It turns raw demand into safe actuator commands: fan pre-run before heating or cooling starts, a minimum run time, fan post-run, and an anti-short-cycle lockout before the next start. It sits between the temperature monitor outputs and the heater, compressor and fan drive pins.

## Interface
Parameters:
- FAN_PRE, default 2: fan pre-run length in cycles (≥1).
- MIN_ON, default 8: minimum heater/compressor run in cycles (≥1).
- FAN_POST, default 4: fan post-run length in cycles (≥1).
- MIN_OFF, default 6: lockout length after post-run in cycles (≥1).
- CNT_W, default 8: timer width; every timing parameter must be ≤ 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  system enable from the user switch.
- heat_req  in  1  heating demand from the temperature monitor.
- cool_req  in  1  cooling demand from the temperature monitor.
- heater_on  out  1  heater drive.
- compressor_on  out  1  cooling compressor drive.
- fan_on  out  1  fan drive.
- state  out  3  current FSM state encoding, for debug.
- fault  out  1  registered; high the cycle after heat_req and cool_req are both sampled high.

## Operation
- State encodings: IDLE=0, PRE=1, HEAT=2, COOL=3, POST=4, LOCKOUT=5. Codes 6 and 7 return to IDLE on the next edge.
- Single down-counter cnt[CNT_W-1:0]. On entry to a timed state it loads N-1, where N is that state's parameter. It decrements while nonzero and holds at 0.
- A request is valid when enable=1 and exactly one of heat_req/cool_req is high. Both high counts as no request and sets fault.
- IDLE:
  - All outputs 0.
  - A valid request moves to PRE, latches mode (heat if heat_req, else cool) and loads FAN_PRE.
- PRE:
  - fan_on=1.
  - When cnt==0, go to HEAT or COOL per the latched mode and load MIN_ON.
  - enable=0 at any point aborts to POST immediately and loads FAN_POST.
  - Request changes during PRE are otherwise ignored.
- HEAT:
  - heater_on=1, fan_on=1.
  - Exit to POST (load FAN_POST) when cnt==0 and any of: heat_req=0, cool_req=1, enable=0.
  - Before cnt reaches 0, no input can end the state.
- COOL: same as HEAT, with compressor_on in place of heater_on and cool_req/heat_req swapped.
- POST:
  - fan_on=1.
  - When cnt==0, go to LOCKOUT and load MIN_OFF.
- LOCKOUT:
  - All outputs 0.
  - When cnt==0, go to IDLE.
  - Requests are ignored; a request still present is accepted in IDLE on the following edge.
- Safety invariants:
  - heater_on and compressor_on are never high together.
  - A direct heat↔cool changeover is impossible; it always passes through POST and LOCKOUT.

## Timing
- Moore outputs, decoded from the registered state. An output changes only on the edge that changes the state.
- Reset: state=IDLE, cnt=0, mode=heat, fault=0, and heater_on=compressor_on=fan_on=0 from the first reset edge.
- rst has priority over everything. A reset during any state, including mid-HEAT or mid-COOL, drops all drives on that same edge.
- Latency, with edge E sampling a valid request in IDLE:
  - fan_on rises after E.
  - heater_on or compressor_on rises after edge E+FAN_PRE.
- State durations:
  - PRE, POST and LOCKOUT each last exactly their parameter in cycles.
  - HEAT and COOL last at least MIN_ON cycles.
- Minimum spacing between a drive falling and the next drive rising: FAN_POST+MIN_OFF+1+FAN_PRE cycles.
- fault is updated every cycle from that cycle's sampled inputs, in every state.

## Test plan
- Reset, then hold heat_req=1, enable=1. Required: fan_on=1 after edge 1; heater_on=1 after edge 3; state=2; heater held while heat_req stays high.
- 1-cycle cool_req pulse in IDLE. Required: compressor_on high for exactly 8 cycles; then fan-only for 4 cycles; then 6 cycles all-off; then state=0.
- During HEAT at cycle 3 of 8, drop heat_req and raise cool_req. Required: heater stays on until MIN_ON expires; POST(4) then LOCKOUT(6); COOL is entered only after passing through IDLE→PRE; compressor_on and heater_on are never high together.
- heat_req=cool_req=1 in IDLE. Required: fault=1 the next cycle; state stays 0; all drives 0.
- Deassert enable during PRE. Required: next state POST; heater/compressor never assert; fan stays on for 4 more cycles.
- Assert rst mid-COOL. Required: all drives 0 and state=0 after that edge; a subsequent request restarts from PRE with no lockout.

Source files
------------

// File: rtl/hvac_sequencer.sv
// HVAC actuator sequencer. Turns heat/cool demand into heater, compressor
// and fan commands with a fan pre-run, a minimum run time, a fan post-run
// and an anti-short-cycle lockout before the next start.
module hvac_sequencer #(
   parameter int FAN_PRE  = 2,
   parameter int MIN_ON   = 8,
   parameter int FAN_POST = 4,
   parameter int MIN_OFF  = 6,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       heat_req,
   input  logic       cool_req,
   output logic       heater_on,
   output logic       compressor_on,
   output logic       fan_on,
   output logic [2:0] state,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_HEAT = 3'd2,
      S_COOL = 3'd3,
      S_POST = 3'd4,
      S_LOCK = 3'd5
   } state_t;

   // Each timed state loads N-1 so that it lasts exactly N cycles.
   localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(FAN_PRE - 1);
   localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0] POST_LD = CNT_W'(FAN_POST - 1);
   localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(MIN_OFF - 1);

   state_t           cur;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] load_val;
   logic             load;
   logic             mode_heat;
   logic             mode_set;
   logic             valid;
   logic             cnt_zero;

   // Both demands at once is a monitor fault and is never treated as a request.
   assign valid    = enable & (heat_req ^ cool_req);
   assign cnt_zero = (cnt == '0);

   // State, timer, latched mode and fault flag; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur       <= S_IDLE;
         cnt       <= '0;
         mode_heat <= 1'b1;
         fault     <= 1'b0;
      end else begin
         cur   <= nxt;
         fault <= heat_req & cool_req;
         if (load)
            cnt <= load_val;
         else if (!cnt_zero)
            cnt <= cnt - CNT_W'(1);
         if (mode_set)
            mode_heat <= heat_req;
      end
   end

   // Next-state and timer-load decisions.
   always_comb begin
      nxt      = cur;
      load     = 1'b0;
      load_val = '0;
      mode_set = 1'b0;
      case (cur)
         S_IDLE: begin
            if (valid) begin
               nxt      = S_PRE;
               load     = 1'b1;
               load_val = PRE_LD;
               mode_set = 1'b1;
            end
         end
         S_PRE: begin
            // Losing enable aborts straight to the fan post-run; the
            // compressor/heater is never started in that case.
            if (!enable) begin
               nxt      = S_POST;
               load     = 1'b1;
               load_val = POST_LD;
            end else if (cnt_zero) begin
               nxt      = mode_heat ? S_HEAT : S_COOL;
               load     = 1'b1;
               load_val = ON_LD;
            end
         end
         S_HEAT: begin
            if (cnt_zero && (!heat_req || cool_req || !enable)) begin
               nxt      = S_POST;
               load     = 1'b1;
               load_val = POST_LD;
            end
         end
         S_COOL: begin
            if (cnt_zero && (!cool_req || heat_req || !enable)) begin
               nxt      = S_POST;
               load     = 1'b1;
               load_val = POST_LD;
            end
         end
         S_POST: begin
            if (cnt_zero) begin
               nxt      = S_LOCK;
               load     = 1'b1;
               load_val = OFF_LD;
            end
         end
         S_LOCK: begin
            if (cnt_zero)
               nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Moore output decode from the registered state only.
   always_comb begin
      heater_on     = (cur == S_HEAT);
      compressor_on = (cur == S_COOL);
      fan_on        = (cur == S_PRE) || (cur == S_HEAT) ||
                      (cur == S_COOL) || (cur == S_POST);
   end

   assign state = cur;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Bench for hvac_sequencer: a table of input segments, each held for n
// cycles with the state expected after every edge. Expected records are
// queued when inputs are driven and popped after the edge.
module tb_hvac_sequencer;

   logic       clk = 1'b0;
   logic       rst, enable, heat_req, cool_req;
   logic       heater_on, compressor_on, fan_on, fault;
   logic [2:0] state;

   hvac_sequencer dut (
      .clk(clk), .rst(rst), .enable(enable), .heat_req(heat_req),
      .cool_req(cool_req), .heater_on(heater_on),
      .compressor_on(compressor_on), .fan_on(fan_on),
      .state(state), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r, en, h, c;
      int         n;
      logic [2:0] st;
      logic       flt;
   } seg_t;

   typedef struct {
      logic [2:0] st;
      logic       ht, cp, fn, flt;
      int         seg;
   } exp_t;

   seg_t tbl[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic exp_t mk_exp(logic [2:0] st, logic flt, int seg);
      exp_t e;
      e.st  = st;
      e.ht  = (st == 3'd2);
      e.cp  = (st == 3'd3);
      e.fn  = (st == 3'd1) || (st == 3'd2) || (st == 3'd3) || (st == 3'd4);
      e.flt = flt;
      e.seg = seg;
      return e;
   endfunction

   task automatic add(logic r, logic en, logic h, logic c, int n,
                      logic [2:0] st, logic flt);
      seg_t s;
      s.r = r; s.en = en; s.h = h; s.c = c; s.n = n; s.st = st; s.flt = flt;
      tbl.push_back(s);
   endtask

   task automatic check_one();
      exp_t e;
      e = sb.pop_front();
      total++;
      if (state !== e.st || heater_on !== e.ht || compressor_on !== e.cp ||
          fan_on !== e.fn || fault !== e.flt) begin
         bad++;
         $display("FAIL seg%0d: got st=%0d ht=%b cp=%b fan=%b flt=%b want st=%0d ht=%b cp=%b fan=%b flt=%b",
                  e.seg, state, heater_on, compressor_on, fan_on, fault,
                  e.st, e.ht, e.cp, e.fn, e.flt);
      end
      total++;
      if (heater_on === 1'b1 && compressor_on === 1'b1) begin
         bad++;
         $display("FAIL excl seg%0d: heater=%b compressor=%b want not both", e.seg,
                  heater_on, compressor_on);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; heat_req = 1'b0; cool_req = 1'b0;

      // 1: reset, then hold heat demand; release after minimum run
      add(1,0,0,0, 1, 3'd0, 0);
      add(0,1,1,0, 2, 3'd1, 0);
      add(0,1,1,0,12, 3'd2, 0);
      add(0,1,0,0, 4, 3'd4, 0);
      add(0,1,0,0, 6, 3'd5, 0);
      add(0,1,0,0, 1, 3'd0, 0);
      // 2: one-cycle cool pulse in idle
      add(0,1,0,1, 1, 3'd1, 0);
      add(0,1,0,0, 1, 3'd1, 0);
      add(0,1,0,0, 8, 3'd3, 0);
      add(0,1,0,0, 4, 3'd4, 0);
      add(0,1,0,0, 6, 3'd5, 0);
      add(0,1,0,0, 2, 3'd0, 0);
      // 3: heat->cool changeover at cycle 3 of minimum run
      add(0,1,1,0, 2, 3'd1, 0);
      add(0,1,1,0, 2, 3'd2, 0);
      add(0,1,0,1, 6, 3'd2, 0);
      add(0,1,0,1, 4, 3'd4, 0);
      add(0,1,0,1, 6, 3'd5, 0);
      add(0,1,0,1, 1, 3'd0, 0);
      add(0,1,0,1, 2, 3'd1, 0);
      add(0,1,0,1, 8, 3'd3, 0);
      add(0,1,0,0, 4, 3'd4, 0);
      add(0,1,0,0, 6, 3'd5, 0);
      add(0,1,0,0, 1, 3'd0, 0);
      // 4: both demands in idle -> fault, no start
      add(0,1,1,1, 2, 3'd0, 1);
      add(0,1,0,0, 1, 3'd0, 0);
      // 5: enable dropped during pre-run
      add(0,1,1,0, 1, 3'd1, 0);
      add(0,0,1,0, 4, 3'd4, 0);
      add(0,0,1,0, 6, 3'd5, 0);
      add(0,0,1,0, 2, 3'd0, 0);
      // 6: reset mid-cool, restart with no lockout
      add(0,1,0,1, 2, 3'd1, 0);
      add(0,1,0,1, 3, 3'd3, 0);
      add(1,1,0,1, 1, 3'd0, 0);
      add(0,1,0,1, 2, 3'd1, 0);
      add(0,1,0,1, 1, 3'd3, 0);
      add(0,1,0,0, 7, 3'd3, 0);
      add(0,1,0,0, 4, 3'd4, 0);
      add(0,1,0,0, 6, 3'd5, 0);
      add(0,1,0,0, 1, 3'd0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            @(negedge clk);
            rst = tbl[i].r; enable = tbl[i].en;
            heat_req = tbl[i].h; cool_req = tbl[i].c;
            sb.push_back(mk_exp(tbl[i].st, tbl[i].flt, i));
            @(posedge clk);
            #1;
            check_one();
         end
      end

      // Hand sequence: fault flag is independent of enable and state.
      @(negedge clk);
      rst = 1'b0; enable = 1'b0; heat_req = 1'b1; cool_req = 1'b1;
      sb.push_back(mk_exp(3'd0, 1'b1, 99));
      @(posedge clk); #1; check_one();
      @(negedge clk);
      heat_req = 1'b0; cool_req = 1'b0;
      sb.push_back(mk_exp(3'd0, 1'b0, 100));
      @(posedge clk); #1; check_one();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
